// File: rtl/serial_alu_frontend.sv
// Bit-serial front end for the 8-bit combinational ALU: shifts in opcode and
// operands LSB first, captures the ALU result, and shifts it back out LSB first.
`timescale 1ns/1ps
module serial_alu_frontend #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              busy,
  output logic              sout,
  output logic              sout_valid,
  output logic              zero_flag,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SEL,
    LOAD_A,
    LOAD_B,
    EXEC,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // The counter restarts from zero on every phase change, so each phase ends at W-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD_SEL;
      end
      LOAD_SEL: begin
        sel_d = {sin, sel_q[SEL_W-1:1]};
        if (cnt_q == CNT_W'(SEL_W - 1)) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      LOAD_A: begin
        a_d = {sin, a_q[DATA_W-1:1]};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = LOAD_B;
          cnt_d   = '0;
        end
      end
      LOAD_B: begin
        b_d = {sin, b_q[DATA_W-1:1]};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        res_d = {1'b0, res_q[DATA_W-1:1]};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    alu_a      = a_q;
    alu_b      = b_q;
    alu_sel    = sel_q;
    zero_flag  = zero_q;
    busy       = (state_q != IDLE);
    sout_valid = (state_q == SHIFT);
    sout       = sout_valid & res_q[0];
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_serial_alu_frontend.sv
// Scoreboard bench for serial_alu_frontend: a behavioural ALU closes the loop,
// expected results are queued per frame and checked by an independent monitor.
`timescale 1ns/1ps
module tb_serial_alu_frontend;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sin = 1'b0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_zero, busy, sout, sout_valid, zero_flag, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    int         done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] col = 8'h00;
  int         nbits = 0;

  serial_alu_frontend #(.DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sin(sin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy), .sout(sout), .sout_valid(sout_valid),
    .zero_flag(zero_flag), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 unsigned a<b
  function automatic logic [7:0] ref_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return {a[6:0], 1'b0};
      3'd6: return {1'b0, a[7:1]};
      default: return (a < b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  assign alu_out  = ref_alu(alu_sel, alu_a, alu_b);
  assign alu_zero = (alu_out == 8'h00);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu_a"}, alu_a, 0);
    checkOutput({tag, "_alu_b"}, alu_b, 0);
    checkOutput({tag, "_alu_sel"}, alu_sel, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sout"}, sout, 0);
    checkOutput({tag, "_sout_valid"}, sout_valid, 0);
    checkOutput({tag, "_zero_flag"}, zero_flag, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Drives one frame starting at the current negedge; returns at the negedge
  // of cycle 30 so a following call starts back-to-back. hold = last cycle
  // start stays high, abort = cycle in which a one-cycle reset is applied.
  task automatic applyStimulus(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                               input int hold, input int abort);
    logic [18:0] bits;
    logic [7:0]  r;
    exp_t        e;
    bits = {b, a, s};
    r = ref_alu(s, a, b);
    e.res = r;
    e.z = (r == 8'h00);
    e.done_cyc = cyc + 29;
    exp_q.push_back(e);
    start = 1'b1;
    sin = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (k > hold) start = 1'b0;
      sin = (k <= 19) ? bits[k-1] : 1'($urandom_range(0, 1));
      if (k == abort) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkAllZero("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      sin = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: assembles serial result bits and retires one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      col = 8'h00;
    end else begin
      if (!sout_valid) checkOutput("sout_low_when_invalid", sout, 0);
      if (sout_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_sout_valid: got 1 expected 0 (cycle %0d)", cyc);
        end
        col = {sout, col[7:1]};
        nbits++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("result", col, mon_e.res);
          checkOutput("result_bits", nbits, 8);
          checkOutput("zero_flag", zero_flag, mon_e.z);
          checkOutput("done_cycle", cyc, mon_e.done_cyc);
        end
        nbits = 0;
        col = 8'h00;
      end
    end
  end

  initial begin
    logic [2:0] rs;
    logic [7:0] ra, rb;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] ADD 0x25+0x1A");
    applyStimulus(3'd0, 8'h25, 8'h1A, 0, 0);
    idleCycles(2);

    $display("[TB] SUB 0x10-0x10");
    applyStimulus(3'd1, 8'h10, 8'h10, 0, 0);
    checkOutput("hold_alu_a", alu_a, 8'h10);
    checkOutput("hold_alu_b", alu_b, 8'h10);
    checkOutput("hold_alu_sel", alu_sel, 3'd1);
    checkOutput("hold_zero_flag", zero_flag, 1);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] sin toggling in IDLE");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      sin = ~sin;
      checkOutput("toggle_busy", busy, 0);
      checkOutput("toggle_sout_valid", sout_valid, 0);
    end
    checkOutput("toggle_alu_a", alu_a, 8'h10);
    checkOutput("toggle_alu_b", alu_b, 8'h10);
    checkOutput("toggle_alu_sel", alu_sel, 3'd1);

    $display("[TB] compare then SHL back-to-back");
    applyStimulus(3'd7, 8'h05, 8'h80, 0, 0);
    applyStimulus(3'd5, 8'h81, 8'($urandom_range(0, 255)), 0, 0);
    idleCycles(3);

    $display("[TB] start held high through frame");
    applyStimulus(3'd2, 8'hF0, 8'h3C, 29, 0);
    @(negedge clk);
    checkOutput("busy_after_hold", busy, 0);
    idleCycles(35);

    $display("[TB] reset during LOAD_B");
    applyStimulus(3'd0, 8'h77, 8'h11, 0, 15);
    idleCycles(35);
    applyStimulus(3'd0, 8'h01, 8'h02, 0, 0);
    idleCycles(1);

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      rs = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (f % 4 == 3) rb = ra;
      applyStimulus(rs, ra, rb, 0, 0);
      idleCycles($urandom_range(0, 3));
    end

    idleCycles(5);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_alu_frontend.md
# serial_alu_frontend

Sequential front end for the 8-bit combinational ALU in the bit-serial CPU datapath. It sits directly upstream and downstream of the ALU. It deserializes a 3-bit opcode and two 8-bit operands from a one-wire serial stream, drives them onto the ALU inputs, and captures the ALU result and zero flag. It then shifts the result back out serially, so the ALU can be used from the bit-serial core.

## Interface

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU width (8).
- SEL_W, 3, opcode width; must equal the ALU selector width (3).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  frame start request; sampled only in IDLE.
- sin  input  1  serial input bit.
- alu_a  output  DATA_W  operand A to ALU (registered).
- alu_b  output  DATA_W  operand B to ALU (registered).
- alu_sel  output  SEL_W  opcode to ALU (registered).
- alu_out  input  DATA_W  ALU result.
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high whenever state != IDLE.
- sout  output  1  serial result bit; 0 when sout_valid low.
- sout_valid  output  1  high while a result bit is on sout.
- zero_flag  output  1  registered copy of alu_zero from the last EXEC.
- done  output  1  one-cycle pulse at frame end.

## Operation

- FSM states, in order: IDLE, LOAD_SEL, LOAD_A, LOAD_B, EXEC, SHIFT, DONE.
- IDLE: start=1 moves to LOAD_SEL and clears the bit counter. sin is not sampled in IDLE.
- LOAD_SEL: samples sin for SEL_W cycles and shifts LSB first into alu_sel, then goes to LOAD_A.
- LOAD_A: samples sin for DATA_W cycles and shifts LSB first into alu_a, then goes to LOAD_B.
- LOAD_B: the same into alu_b for DATA_W cycles, then goes to EXEC.
- Shift-in rule: reg <= {sin, reg[W-1:1]}. After W samples, the first sampled bit is at bit 0.
- EXEC: one cycle. Captures alu_out into the result shift register and alu_zero into zero_flag, then goes to SHIFT.
- SHIFT: DATA_W cycles.
  - sout = result[0] and sout_valid = 1.
  - The result register shifts right by one each cycle, so the result leaves LSB first.
- DONE: one cycle with done = 1, then returns to IDLE.
- Bit counter width: ceil(log2(DATA_W)) + 1. It is reset to 0 on every state change and never wraps within a phase.
- alu_sel, alu_a and alu_b change only during their own load phase. They hold their values through EXEC, SHIFT, DONE and IDLE until the next frame overwrites them.
- zero_flag holds its value until the next EXEC.
- start while busy is ignored; it is not queued.
- Reset (rst_n low, any state, any cycle) takes effect immediately:
  - state = IDLE.
  - alu_a, alu_b, alu_sel, result register, counter = 0.
  - busy, sout, sout_valid, zero_flag, done = 0.
  - Any partial frame is discarded.
- After rst_n deasserts, start must be sampled high again to begin a frame.

## Timing

- Cycle 0 is the edge where start is sampled high in IDLE.
- busy is high from cycle 1 through cycle 29 inclusive.
- Opcode: sin is sampled at the edges ending cycles 1..3, giving opcode bits 0..2.
- Operand A: sin is sampled during cycles 4..11, giving A bits 0..7.
- Operand B: sin is sampled during cycles 12..19, giving B bits 0..7.
- alu_b is complete at the start of cycle 20 (EXEC). The ALU has one full cycle of combinational settle time; the result is captured at the end of cycle 20.
- Result: sout_valid = 1 in cycles 21..28, with sout carrying result bits 0..7.
- done = 1 in cycle 29. In cycle 30 the block is IDLE and busy = 0.
- A start sampled in cycle 29 is ignored. A start sampled in cycle 30 begins a new frame.
- Frame latency is 30 cycles, from accepted start to return to IDLE.
- Throughput is one frame per 30 cycles minimum.

## Test plan

- ADD, opcode 000, A=0x25, B=0x1A → sout bits 1,1,1,1,1,1,0,0 (0x3F) in cycles 21..28; zero_flag=0; done in cycle 29.
- SUB, opcode 001, A=0x10, B=0x10 → sout 0x00 (all zero bits); zero_flag=1; alu_a/alu_b still 0x10 during IDLE after the frame.
- Compare, opcode 111, A=0x05, B=0x80 → sout 0x01; then SHL, opcode 101, A=0x81 → sout 0x02. Both frames back-to-back, with the second start in cycle 30.
- start held high for cycles 0..29 → exactly one frame; no restart until start is sampled in cycle 30.
- rst_n low for one cycle in cycle 15 (LOAD_B) → all outputs 0 immediately; no sout_valid or done follows. The next frame with A=0x01, B=0x02, ADD yields 0x03.
- sin toggling while IDLE with start=0 → alu_a, alu_b and alu_sel unchanged; busy=0; sout_valid=0.
